// File: rtl/weight_fetcher_if.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | weight_fetcher_if                                                      |
// | Command, weight-buffer read port and MMU row bus of the weight fetcher.|
// | Revision: 1.0                                                          |
// +------------------------------------------------------------------------+
interface weight_fetcher_if #(
  parameter int MATRIX_WIDTH = 4,
  parameter int ADDR_WIDTH   = 16,
  parameter int LEN_WIDTH    = 16
);
  localparam int c_IDX_W = (MATRIX_WIDTH > 1) ? $clog2(MATRIX_WIDTH) : 1;

  logic                      cmd_valid;
  logic                      cmd_ready;
  logic [ADDR_WIDTH-1:0]     cmd_addr;
  logic [LEN_WIDTH-1:0]      cmd_len;
  logic                      buf_en;
  logic [ADDR_WIDTH-1:0]     buf_addr;
  logic [8*MATRIX_WIDTH-1:0] buf_rdata;
  logic                      row_valid;
  logic [8*MATRIX_WIDTH-1:0] row_data;
  logic [c_IDX_W-1:0]        row_idx;
  logic                      activate;
  logic                      busy;
  logic                      done;

  // Environment side: issues commands, serves buffer reads, consumes rows.
  modport master (
    output cmd_valid, cmd_addr, cmd_len, buf_rdata,
    input  cmd_ready, buf_en, buf_addr, row_valid, row_data, row_idx,
           activate, busy, done
  );

  // Fetcher side.
  modport slave (
    input  cmd_valid, cmd_addr, cmd_len, buf_rdata,
    output cmd_ready, buf_en, buf_addr, row_valid, row_data, row_idx,
           activate, busy, done
  );
endinterface
`default_nettype wire

// File: rtl/weight_fetcher.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | weight_fetcher                                                         |
// | Streams weight rows from the weight buffer into the MMU weight loader. |
// | Revision: 1.0                                                          |
// +------------------------------------------------------------------------+
module weight_fetcher #(
  parameter int MATRIX_WIDTH = 4,
  parameter int ADDR_WIDTH   = 16,
  parameter int LEN_WIDTH    = 16,
  parameter int READ_LATENCY = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  weight_fetcher_if.slave  wf
);
  localparam int c_IDX_W  = (MATRIX_WIDTH > 1) ? $clog2(MATRIX_WIDTH) : 1;
  localparam int c_DATA_W = 8 * MATRIX_WIDTH;
  localparam logic [c_IDX_W-1:0]   c_TILE_LAST = c_IDX_W'(MATRIX_WIDTH - 1);
  localparam logic [c_IDX_W-1:0]   c_IDX_ONE   = c_IDX_W'(1);
  localparam logic [LEN_WIDTH-1:0] c_LEN_ONE   = LEN_WIDTH'(1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2,
    FIN   = 2'd3
  } state_t;

  state_t                  r_state;
  logic [ADDR_WIDTH-1:0]   r_base;
  logic [LEN_WIDTH-1:0]    r_len;
  logic [LEN_WIDTH-1:0]    r_issue_cnt;
  logic [LEN_WIDTH-1:0]    r_ret_cnt;
  logic [c_IDX_W-1:0]      r_tile_pos;
  logic [READ_LATENCY-1:0] r_pipe;
  logic                    r_cmd_ready;
  logic                    r_buf_en;
  logic [ADDR_WIDTH-1:0]   r_buf_addr;
  logic                    r_row_valid;
  logic [c_DATA_W-1:0]     r_row_data;
  logic [c_IDX_W-1:0]      r_row_idx;
  logic                    r_activate;
  logic                    r_busy;
  logic                    r_done;

  logic                    w_pipe_out;
  logic [LEN_WIDTH-1:0]    w_len_m1;
  logic                    w_last_row;

  assign w_pipe_out = r_pipe[READ_LATENCY-1];
  assign w_len_m1   = r_len - c_LEN_ONE;
  assign w_last_row = (r_ret_cnt == w_len_m1);

  // Read-valid tracker; stalls together with the buffer so data and flag stay aligned.
  generate
    if (READ_LATENCY == 1) begin : g_pipe_single
      always_ff @(posedge clk or negedge rst) begin
        if (!rst)        r_pipe <= '0;
        else if (enable) r_pipe <= r_buf_en;
      end
    end else begin : g_pipe_shift
      always_ff @(posedge clk or negedge rst) begin
        if (!rst)        r_pipe <= '0;
        else if (enable) r_pipe <= {r_pipe[READ_LATENCY-2:0], r_buf_en};
      end
    end
  endgenerate

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= IDLE;
      r_base      <= '0;
      r_len       <= '0;
      r_issue_cnt <= '0;
      r_ret_cnt   <= '0;
      r_tile_pos  <= '0;
      r_cmd_ready <= 1'b1;
      r_buf_en    <= 1'b0;
      r_buf_addr  <= '0;
      r_row_valid <= 1'b0;
      r_row_data  <= '0;
      r_row_idx   <= '0;
      r_activate  <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
    end else if (!enable) begin
      // Pulses drop during a stall so the consumer never sees them twice.
      r_row_valid <= 1'b0;
      r_activate  <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_row_valid <= w_pipe_out;
      r_activate  <= 1'b0;
      r_done      <= 1'b0;

      if (w_pipe_out) begin
        r_row_data <= wf.buf_rdata;
        r_row_idx  <= r_tile_pos;
        r_activate <= (r_tile_pos == c_TILE_LAST) || w_last_row;
        r_ret_cnt  <= r_ret_cnt + c_LEN_ONE;
        r_tile_pos <= (r_tile_pos == c_TILE_LAST) ? '0 : r_tile_pos + c_IDX_ONE;
      end

      case (r_state)
        IDLE: begin
          r_cmd_ready <= 1'b1;
          r_busy      <= 1'b0;
          r_buf_en    <= 1'b0;
          if (wf.cmd_valid && r_cmd_ready) begin
            r_base      <= wf.cmd_addr;
            r_len       <= wf.cmd_len;
            r_issue_cnt <= '0;
            r_ret_cnt   <= '0;
            r_tile_pos  <= '0;
            r_cmd_ready <= 1'b0;
            r_busy      <= 1'b1;
            r_state     <= (wf.cmd_len == '0) ? FIN : ISSUE;
          end
        end
        ISSUE: begin
          r_buf_en    <= 1'b1;
          r_buf_addr  <= r_base + ADDR_WIDTH'(r_issue_cnt);
          r_issue_cnt <= r_issue_cnt + c_LEN_ONE;
          if (r_issue_cnt == w_len_m1) r_state <= DRAIN;
        end
        DRAIN: begin
          r_buf_en <= 1'b0;
          // Leave as the final row is being registered so done follows it directly.
          if ((r_ret_cnt == r_len) || (w_pipe_out && w_last_row)) r_state <= FIN;
        end
        FIN: begin
          r_done      <= 1'b1;
          r_busy      <= 1'b0;
          r_cmd_ready <= 1'b1;
          r_state     <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign wf.cmd_ready = r_cmd_ready;
  assign wf.buf_en    = r_buf_en;
  assign wf.buf_addr  = r_buf_addr;
  assign wf.row_valid = r_row_valid;
  assign wf.row_data  = r_row_data;
  assign wf.row_idx   = r_row_idx;
  assign wf.activate  = r_activate;
  assign wf.busy      = r_busy;
  assign wf.done      = r_done;
endmodule
`default_nettype wire

// File: tb/tb_weight_fetcher.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | tb_weight_fetcher                                                      |
// | Self-checking bench: buffer model plus queue-based row/address model.  |
// | Revision: 1.0                                                          |
// +------------------------------------------------------------------------+
module tb_weight_fetcher;
  localparam int c_MW = 4;
  localparam int c_AW = 16;
  localparam int c_LW = 16;
  localparam int c_RL = 3;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic enable = 1'b1;

  weight_fetcher_if #(.MATRIX_WIDTH(c_MW), .ADDR_WIDTH(c_AW), .LEN_WIDTH(c_LW)) wf ();

  weight_fetcher #(
    .MATRIX_WIDTH(c_MW), .ADDR_WIDTH(c_AW), .LEN_WIDTH(c_LW), .READ_LATENCY(c_RL)
  ) dut (
    .clk(clk), .rst(rst), .enable(enable), .wf(wf.slave)
  );

  always #5 clk = ~clk;

  // Buffer content: byte0 = high address byte, byte j>0 = (addr*j) mod 256.
  function automatic logic [31:0] row_val(input logic [15:0] a);
    logic [31:0] r;
    r[7:0] = a[15:8];
    for (int j = 1; j < c_MW; j++) r[8*j +: 8] = 8'((32'(a) * j) & 32'hFF);
    return r;
  endfunction

  // Weight buffer with fixed read latency, frozen by enable like the real one.
  logic [31:0] bpipe [c_RL];
  always @(posedge clk) begin
    if (enable) begin
      bpipe[0] <= wf.buf_en ? row_val(wf.buf_addr) : 32'hA5A5_A5A5;
      for (int k = 1; k < c_RL; k++) bpipe[k] <= bpipe[k-1];
    end
  end
  assign wf.buf_rdata = bpipe[c_RL-1];

  int n_checks = 0;
  int n_fail   = 0;
  int cyc = 0, n_issue = 0, iss_base = 0, last_iss = 0, last_row = 0, acc_cyc = 0, pending = 0;
  bit tmg = 1'b0;
  bit prev_en = 1'b1;
  logic [15:0] cur_len = '0;
  logic [15:0] exp_addr [$];
  logic [31:0] exp_data [$];
  logic [1:0]  exp_idx  [$];
  logic        exp_act  [$];

  logic        d_valid = 1'b0;
  logic        d_en = 1'b1;
  logic [15:0] d_addr = '0;
  logic [15:0] d_len = '0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic monitor();
    logic [15:0] a;
    if (!rst) begin
      prev_en = 1'b1;
      return;
    end
    check("act_no_row", wf.activate & ~wf.row_valid, 0);
    check("ready_busy", wf.cmd_ready & wf.busy, 0);
    if (!prev_en) check("stall_quiet", {wf.row_valid, wf.activate, wf.done}, 0);
    if (wf.buf_en && enable) begin
      if (exp_addr.size() == 0) check("addr_extra", wf.buf_en, 0);
      else begin
        a = exp_addr.pop_front();
        check("buf_addr", wf.buf_addr, a);
        if (tmg && n_issue > iss_base) check("issue_gap", cyc - last_iss, 1);
      end
      n_issue++;
      last_iss = cyc;
    end
    if (wf.row_valid) begin
      if (exp_data.size() == 0) check("row_extra", wf.row_valid, 0);
      else begin
        check("row_data", wf.row_data, exp_data.pop_front());
        check("row_idx", wf.row_idx, exp_idx.pop_front());
        check("activate", wf.activate, exp_act.pop_front());
      end
      last_row = cyc;
    end
    if (wf.done) begin
      check("done_extra", wf.done, pending > 0);
      if (pending > 0) begin
        pending--;
        if (tmg) check("done_time", cyc, (cur_len == 0) ? acc_cyc + 2 : last_row + 1);
      end
    end
    prev_en = enable;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    wf.cmd_valid = d_valid;
    wf.cmd_addr  = d_addr;
    wf.cmd_len   = d_len;
    enable       = d_en;
    @(negedge clk);
    cyc++;
    monitor();
  endtask

  // Present a command and wait (bounded) for it to be taken; expectations are
  // queued in the cycle of acceptance.
  task automatic issue_cmd(input logic [15:0] a, input logic [15:0] n, input bit t);
    bit ok = 1'b0;
    d_addr = a; d_len = n; d_valid = 1'b1; d_en = 1'b1;
    for (int k = 0; k < 300 && !ok; k++) begin
      tick();
      if (wf.cmd_ready && wf.cmd_valid && enable) begin
        ok = 1'b1;
        check("accept_idle", pending, 0);
        for (int i = 0; i < int'(n); i++) begin
          exp_addr.push_back(a + 16'(i));
          exp_data.push_back(row_val(a + 16'(i)));
          exp_idx.push_back(2'(i % c_MW));
          exp_act.push_back(((i % c_MW) == c_MW - 1) || (i == int'(n) - 1));
        end
        pending++;
        tmg = t; cur_len = n; acc_cyc = cyc; iss_base = n_issue;
      end
    end
    check("cmd_accept", ok, 1);
    d_valid = 1'b0; d_addr = 16'($urandom); d_len = 16'($urandom);
  endtask

  task automatic wait_done(input int prob, input int stall_after, input int stall_len);
    bit stalled = 1'b0;
    for (int k = 0; k < 3000 && pending > 0; k++) begin
      if (stall_len > 0 && !stalled && n_issue >= iss_base + stall_after) begin
        repeat (stall_len) begin
          d_en = 1'b0;
          tick();
        end
        stalled = 1'b1;
      end
      d_en = ($urandom_range(99) < prob) ? 1'b0 : 1'b1;
      tick();
    end
    d_en = 1'b1;
    check("cmd_done", pending, 0);
    repeat (6) tick();
    check("addr_left", exp_addr.size(), 0);
    check("rows_left", exp_data.size(), 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    wf.cmd_valid = 1'b0;
    wf.cmd_addr  = '0;
    wf.cmd_len   = '0;
    repeat (3) tick();
    check("rst_ready", wf.cmd_ready, 1);
    check("rst_outs", {wf.buf_en, wf.row_valid, wf.activate, wf.busy, wf.done}, 0);
    check("rst_buses", {wf.buf_addr, wf.row_data, wf.row_idx}, 0);
    #2 rst = 1'b1;

    // Single tile, multi/partial tile, stall, wrap, zero length
    issue_cmd(16'h0000, 16'd4, 1'b1);  wait_done(0, 0, 0);
    issue_cmd(16'h0008, 16'd6, 1'b1);  wait_done(0, 0, 0);
    issue_cmd(16'h0040, 16'd4, 1'b0);  wait_done(0, 2, 5);
    issue_cmd(16'hFFFE, 16'd4, 1'b1);  wait_done(0, 0, 0);
    issue_cmd(16'h1234, 16'd0, 1'b1);  wait_done(0, 0, 0);

    // Back-to-back: second command held valid while the first is busy
    issue_cmd(16'h0200, 16'd5, 1'b1);
    issue_cmd(16'h0300, 16'd3, 1'b1);
    wait_done(0, 0, 0);

    // Reset in the middle of issuing
    issue_cmd(16'h0100, 16'd8, 1'b0);
    for (int k = 0; k < 50 && n_issue < iss_base + 3; k++) tick();
    #2 rst = 1'b0;
    #1;
    check("abort_buf_en", wf.buf_en, 0);
    check("abort_busy", wf.busy, 0);
    check("abort_ready", wf.cmd_ready, 1);
    exp_addr.delete(); exp_data.delete(); exp_idx.delete(); exp_act.delete();
    pending = 0;
    tick(); tick();
    #2 rst = 1'b1;
    repeat (12) tick();

    // Randomised commands, half of them under random stalls
    for (int t = 0; t < 12; t++) begin
      issue_cmd(16'($urandom), 16'($urandom_range(0, 13)), 1'b0);
      wait_done((t % 2 == 1) ? 30 : 0, 0, 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
`default_nettype wire
